uart_rx_deserializer: RTL and testbench

Serial-to-parallel UART receiver that sits directly upstream of the receive FIFO. It synchronizes the asynchronous serial line, oversamples each bit and majority-votes it, then checks the stop bit and optional parity. Each good character is presented on `Rx_Data` with a one-cycle `Data_Rdy` strobe, which is the FIFO's write strobe. Framing and parity errors are reported on separate strobes, and errored characters are never written.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_deserializer.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and default frame geometry for the receiver,
// transmitter and FIFO.
package uart_pkg;

  localparam int unsigned DefaultDataBits   = 8;
  localparam int unsigned DefaultOversample = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: a one-cycle o_tick every CLK_DIV cycles while enabled.
// Held at zero when disabled; i_restart realigns it so the next tick is CLK_DIV cycles away.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (!i_en || i_restart) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntLast) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_tick = i_en && !i_restart && (r_cnt == CntLast);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: synchronises Rx_In, majority-votes three mid-bit samples, checks stop bit
// and optional parity (compiled in with `define UART_RX_PARITY_EN).
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefaultDataBits,
  parameter int unsigned OVERSAMPLE = DefaultOversample,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx_In,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Data_Rdy,
  output logic                 Framing_Error,
  output logic                 Parity_Error,
  output logic                 Rx_Busy
);

  localparam int unsigned PhW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  // Tick k starts on divider pulse k; the pulse ending tick k-1 therefore samples tick k.
  localparam logic [PhW-1:0] PhSample0 = PhW'(OVERSAMPLE / 2 - 2);
  localparam logic [PhW-1:0] PhSample1 = PhW'(OVERSAMPLE / 2 - 1);
  localparam logic [PhW-1:0] PhSample2 = PhW'(OVERSAMPLE / 2);
  localparam logic [PhW-1:0] PhDecide  = PhW'(OVERSAMPLE / 2 + 1);
  localparam logic [PhW-1:0] PhLast    = PhW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic                 w_rx_s;
  logic                 w_start_edge;
  logic                 w_tick;
  logic                 w_tick_en;

  uart_state_e          r_state,   w_state_d;
  logic [PhW-1:0]       r_phase,   w_phase_d;
  logic [2:0]           r_votes,   w_votes_d;
  logic [BitW-1:0]      r_bit_idx, w_bit_idx_d;
  logic [DATA_BITS-1:0] r_shift,   w_shift_d;
  logic                 r_par_acc, w_par_acc_d;
  logic [DATA_BITS-1:0] r_data,    w_data_d;
  logic                 r_rdy,     w_rdy_d;
  logic                 r_ferr,    w_ferr_d;
  logic                 r_perr,    w_perr_d;

  logic                 w_vote;
  logic                 w_sample;
  logic                 w_decide;
  logic                 w_bit_end;
  logic                 w_par_bad;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], Rx_In};
      r_rx_prev <= w_rx_s;
    end
  end

  assign w_rx_s       = r_sync[1];
  assign w_start_edge = (r_state == StIdle) && r_rx_prev && !w_rx_s;
  assign w_tick_en    = (r_state != StIdle);

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .i_clk    (Clk),
    .i_rst    (Rst),
    .i_en     (w_tick_en),
    .i_restart(w_start_edge),
    .o_tick   (w_tick)
  );

  assign w_vote    = maj3(r_votes);
  assign w_sample  = w_tick && ((r_phase == PhSample0) || (r_phase == PhSample1) ||
                                (r_phase == PhSample2));
  assign w_decide  = w_tick && (r_phase == PhDecide);
  assign w_bit_end = w_tick && (r_phase == PhLast);
  // Accumulator starts at the odd/even seed, so after data and parity bit it is 1 on mismatch.
  assign w_par_bad = ParityEn & r_par_acc;

  always_comb begin
    w_state_d   = r_state;
    w_phase_d   = r_phase;
    w_votes_d   = r_votes;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_par_acc_d = r_par_acc;
    w_data_d    = r_data;
    w_rdy_d     = 1'b0;
    w_ferr_d    = 1'b0;
    w_perr_d    = 1'b0;

    if (w_tick) begin
      w_phase_d = (r_phase == PhLast) ? '0 : r_phase + PhW'(1);
    end
    if (w_sample) begin
      w_votes_d = {r_votes[1:0], w_rx_s};
    end

    unique case (r_state)
      StIdle: begin
        w_phase_d   = '0;
        w_bit_idx_d = '0;
        w_par_acc_d = (PARITY_ODD != 0);
        if (w_start_edge) begin
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (w_decide && w_vote) begin
          w_state_d = StIdle;
        end else if (w_bit_end) begin
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_decide) begin
          w_shift_d   = {w_vote, r_shift[DATA_BITS-1:1]};
          w_par_acc_d = r_par_acc ^ w_vote;
        end
        if (w_bit_end) begin
          if (r_bit_idx == BitLast) begin
            w_bit_idx_d = '0;
            w_state_d   = ParityEn ? StParity : StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + BitW'(1);
          end
        end
      end
      StParity: begin
        if (w_decide) begin
          w_par_acc_d = r_par_acc ^ w_vote;
        end
        if (w_bit_end) begin
          w_state_d = StStop;
        end
      end
      StStop: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (w_decide) begin
          if (!w_vote) begin
            w_ferr_d  = 1'b1;
            w_state_d = StBreak;
          end else if (w_par_bad) begin
            w_perr_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_rdy_d   = 1'b1;
            w_data_d  = r_shift;
            w_state_d = StIdle;
          end
        end
      end
      StBreak: begin
        if (w_rx_s) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_votes   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_data    <= '0;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_phase   <= w_phase_d;
      r_votes   <= w_votes_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_par_acc <= w_par_acc_d;
      r_data    <= w_data_d;
      r_rdy     <= w_rdy_d;
      r_ferr    <= w_ferr_d;
      r_perr    <= w_perr_d;
    end
  end

  assign Rx_Data       = r_data;
  assign Data_Rdy      = r_rdy;
  assign Framing_Error = r_ferr;
  assign Parity_Error  = r_perr;
  assign Rx_Busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed and random frames against a frame-level outcome model of uart_rx_deserializer.
module tb_uart_rx_deserializer;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Os       = 16;
  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned BitClk   = Os * ClkDiv;
  localparam int unsigned ParOdd   = 1;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ParEn = 1;
`else
  localparam int unsigned ParEn = 0;
`endif

  logic                Clk = 1'b0;
  logic                Rst;
  logic                Rx_In;
  logic [DataBits-1:0] Rx_Data;
  logic                Data_Rdy;
  logic                Framing_Error;
  logic                Parity_Error;
  logic                Rx_Busy;

  uart_rx_deserializer #(
    .DATA_BITS (DataBits),
    .OVERSAMPLE(Os),
    .CLK_DIV   (ClkDiv),
    .PARITY_ODD(ParOdd)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Rx_In        (Rx_In),
    .Rx_Data      (Rx_Data),
    .Data_Rdy     (Data_Rdy),
    .Framing_Error(Framing_Error),
    .Parity_Error (Parity_Error),
    .Rx_Busy      (Rx_Busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Event encoding: {kind, data}; kind 0 = good char, 1 = framing, 2 = parity.
  logic [DataBits+1:0] obs_q[$];
  logic [DataBits+1:0] exp_q[$];
  int unsigned         n_multi = 0;
  int unsigned         n_bad_upd = 0;
  logic [DataBits-1:0] prev_data = '0;
  time                 t_fall = 0;
  time                 t_rdy = 0;

  always @(negedge Clk) begin
    if (Data_Rdy) begin
      obs_q.push_back({2'd0, Rx_Data});
      t_rdy = $time;
    end
    if (Framing_Error) obs_q.push_back({2'd1, 8'h00});
    if (Parity_Error) obs_q.push_back({2'd2, 8'h00});
    if ((int'(Data_Rdy) + int'(Framing_Error) + int'(Parity_Error)) > 1) n_multi++;
    if (!Rst && !Data_Rdy && (Rx_Data !== prev_data)) n_bad_upd++;
    prev_data = Rx_Data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_parity(input logic [DataBits-1:0] d);
    return logic'(($countones(d) + ParOdd) % 2);
  endfunction

  // Frame-level model: stop low beats everything, then parity, else the character lands.
  task automatic expect_frame(input logic [DataBits-1:0] d, input logic stop, input logic par);
    if (!stop) exp_q.push_back({2'd1, 8'h00});
    else if ((ParEn != 0) && (par !== good_parity(d))) exp_q.push_back({2'd2, 8'h00});
    else exp_q.push_back({2'd0, d});
  endtask

  task automatic check_events(input string tag);
    chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk($sformatf("%s_ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    Rx_In = v;
    if (glitch) begin
      repeat (30) @(negedge Clk);
      Rx_In = ~v;
      repeat (4) @(negedge Clk);
      Rx_In = v;
      repeat (BitClk - 34) @(negedge Clk);
    end else begin
      repeat (BitClk) @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [DataBits-1:0] d, input logic stop, input logic par,
                            input int noise_bit);
    t_fall = $time;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < DataBits; i++) drive_bit(d[i], i == noise_bit);
    if (ParEn != 0) drive_bit(par, 1'b0);
    drive_bit(stop, 1'b0);
  endtask

  logic [DataBits-1:0] d;
  logic                stop;
  logic                par;
  int unsigned         gap;
  int unsigned         lat;
  int unsigned         lat_lo;

  initial begin
    Rst   = 1'b0;
    Rx_In = 1'b1;
    #2 Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_data", 32'(Rx_Data), 32'h0);
    chk("reset_busy", 32'(Rx_Busy), 32'h0);
    chk("reset_strobes", {29'h0, Data_Rdy, Framing_Error, Parity_Error}, 32'h0);
    Rst = 1'b0;
    repeat (BitClk) @(negedge Clk);

    // Good frame and latency from the Rx_In edge
    expect_frame(8'hA5, 1'b1, good_parity(8'hA5));
    send_frame(8'hA5, 1'b1, good_parity(8'hA5), -1);
    check_events("good_a5");
    chk("good_data", 32'(Rx_Data), 32'hA5);
    chk("good_busy_after_stop", 32'(Rx_Busy), 32'h0);
    lat    = int'((t_rdy - t_fall) / 10);
    lat_lo = (1 + DataBits + ParEn) * BitClk + (Os / 2 + 2) * ClkDiv + 1;
    chk($sformatf("latency_%0d_in_%0d_%0d", lat, lat_lo, lat_lo + 4),
        32'((lat >= lat_lo) && (lat <= lat_lo + 4)), 32'h1);

    // Glitch: short low pulse must abort in START
    Rx_In = 1'b0;
    repeat (10) @(negedge Clk);
    chk("glitch_busy_in_start", 32'(Rx_Busy), 32'h1);
    repeat (10) @(negedge Clk);
    Rx_In = 1'b1;
    repeat (40) @(negedge Clk);
    chk("glitch_back_idle", 32'(Rx_Busy), 32'h0);
    check_events("glitch");
    repeat (BitClk) @(negedge Clk);

    // Framing error, line held low, then recovery
    expect_frame(8'h3C, 1'b0, ~good_parity(8'h3C));
    send_frame(8'h3C, 1'b0, ~good_parity(8'h3C), -1);
    repeat (200) @(negedge Clk);
    chk("break_busy", 32'(Rx_Busy), 32'h1);
    check_events("framing");
    chk("framing_data_held", 32'(Rx_Data), 32'hA5);
    Rx_In = 1'b1;
    repeat (8) @(negedge Clk);
    chk("break_exit_idle", 32'(Rx_Busy), 32'h0);
    repeat (BitClk) @(negedge Clk);
    expect_frame(8'h55, 1'b1, good_parity(8'h55));
    send_frame(8'h55, 1'b1, good_parity(8'h55), -1);
    check_events("after_break");

    // Noise pulse on data bit 3 is voted out
    expect_frame(8'h00, 1'b1, good_parity(8'h00));
    send_frame(8'h00, 1'b1, good_parity(8'h00), 3);
    check_events("noise");

    // Back-to-back frames
    expect_frame(8'h00, 1'b1, good_parity(8'h00));
    expect_frame(8'hFF, 1'b1, good_parity(8'hFF));
    send_frame(8'h00, 1'b1, good_parity(8'h00), -1);
    send_frame(8'hFF, 1'b1, good_parity(8'hFF), -1);
    check_events("back_to_back");

    // Reset in the middle of data bit 4
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    Rx_In = 1'b0;
    repeat (BitClk / 2) @(negedge Clk);
    chk("pre_reset_busy", 32'(Rx_Busy), 32'h1);
    #2 Rst = 1'b1;
    #1;
    chk("async_reset_data", 32'(Rx_Data), 32'h0);
    chk("async_reset_busy", 32'(Rx_Busy), 32'h0);
    chk("async_reset_strobes", {29'h0, Data_Rdy, Framing_Error, Parity_Error}, 32'h0);
    Rx_In = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    repeat (BitClk) @(negedge Clk);
    check_events("reset_abort");
    expect_frame(8'h81, 1'b1, good_parity(8'h81));
    send_frame(8'h81, 1'b1, good_parity(8'h81), -1);
    check_events("after_reset");

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h03, 1'b1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, -1);
    check_events("parity_good");
    expect_frame(8'h03, 1'b1, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, -1);
    check_events("parity_bad");
    chk("parity_data_held", 32'(Rx_Data), 32'h03);
`endif

    // Random frames, occasional bad stop or parity bit, random idle gaps
    for (int k = 0; k < 12; k++) begin
      d    = DataBits'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = good_parity(d) ^ ($urandom_range(0, 3) == 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      expect_frame(d, stop, par);
      send_frame(d, stop, par, -1);
      Rx_In = 1'b1;
      repeat (gap * BitClk) @(negedge Clk);
    end
    repeat (BitClk) @(negedge Clk);
    check_events("random");

    chk("strobe_exclusive", n_multi, 0);
    chk("data_changes_only_with_rdy", n_bad_upd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
